alu_md: RTL and testbench
=========================

# alu_md

Parametrised next-generation MIPS execute-stage ALU. It keeps the single-cycle combinational integer ALU and adds an iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake. It sits in the EXE stage. The pipeline control stalls on `md_busy` and reads HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Must be even and ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, WIDTH: operand A. Also the shift amount, taken from `a[SHW-1:0]`.
- `b`, input, WIDTH: operand B.
- `oper`, input, 4: ALU operation, using the `EXE_ALU_*` codes from `mips_define.vh`.
- `sign`, input, 1: 1 selects signed SLT/SR/MULT/DIV; 0 selects unsigned.
- `result`, output, WIDTH: combinational ALU result.
- `md_start`, input, 1: request a multiply/divide unit operation.
- `md_op`, input, 2: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `md_busy`, output, 1: iterative operation in progress.
- `md_done`, output, 1: one-cycle pulse when HI/LO hold a new MULT/DIV result.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- ALU is combinational. `result` defaults to 0 for undefined `oper`.
  - ADD/SUB/AND/OR/XOR/NOR: as named, modulo 2^WIDTH.
  - SLT: `sign` selects signed or unsigned compare. Result is 1 or 0, zero-extended.
  - LUI: `{b[WIDTH/2-1:0], WIDTH/2 zeros}`.
  - SL: `b << a[SHW-1:0]`.
  - SR: arithmetic shift when `sign`=1, logical when `sign`=0.
- MD state machine has three states: IDLE, RUN, FIX.
  - IDLE with `md_start` and `md_op`=MULT or DIV:
    - latch operands (absolute values if `sign`) and the result-sign flags;
    - set counter = WIDTH;
    - go to RUN.
  - IDLE with `md_start` and MTHI/MTLO: `hi`/`lo` ← `a` at that edge. State stays IDLE, no busy, no done.
  - RUN: one iteration per edge, counter decrements. Counter reaching 0 moves to FIX.
    - MULT is shift-add, producing a 2·WIDTH product.
    - DIV is restoring division, producing quotient and remainder.
  - FIX: apply sign correction and write HI/LO, then return to IDLE.
    - MULT: `{hi,lo}` = product.
    - DIV: `lo` = quotient, `hi` = remainder. Remainder takes the dividend's sign.
- Divide by zero (either signedness): `lo` = all ones, `hi` = `a`. The operation runs the full latency.
- Signed DIV of MIN by −1: `lo` = MIN, `hi` = 0.
- `md_start` while `md_busy` is ignored. This includes MTHI/MTLO. Operands are not re-latched.
- `a`, `b` and `sign` may change after the accept edge without affecting the result in flight.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - state IDLE, counter 0;
  - `hi` = 0, `lo` = 0;
  - `md_busy` = 0, `md_done` = 0.
  - Asserting reset mid-operation aborts the operation. No HI/LO write occurs.
- `result` has zero latency and does not depend on clock or reset.
- MULT/DIV accepted at edge E0:
  - `md_busy` = 1 from after E0 through edge E(WIDTH+1);
  - FIX writes HI/LO at edge E(WIDTH+1);
  - `md_done` = 1 for exactly the cycle after E(WIDTH+1), with `md_busy` = 0 in that cycle;
  - total latency is WIDTH+1 edges. Earliest next accept is edge E(WIDTH+2).
- `md_start` during the `md_done` cycle is accepted. A back-to-back operation therefore gives one done pulse, then busy again.
- `md_busy` and `md_done` are registered outputs. `hi` and `lo` are registers.

## Configuration
- `ALU_MD_DIV_EN` defined: DIV is implemented as specified.
- `ALU_MD_DIV_EN` undefined: the divider datapath is not compiled.
  - `md_op`=DIV is accepted but takes the MULT timing path.
  - At FIX, HI/LO are left unchanged. `md_done` still pulses at the same cycle.
  - MULT, MTHI, MTLO and the ALU are unaffected.

## Test plan
All scenarios use WIDTH=32.
- Reset mid-MULT: `rst_n` low at E10 → `hi`=`lo`=0, `md_busy`=0, no `md_done`. After release, MTLO with `a`=0x1234 → `lo`=0x1234 next cycle.
- Signed MULT: `a`=−7, `b`=3, `sign`=1 → at E33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `md_done` high exactly one cycle, `md_busy` high for 33 cycles.
- Divides:
  - DIVU 100/7 → `lo`=0xE, `hi`=0x2.
  - Signed DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
- `md_start` MTHI pulsed at E5 of a running MULT → ignored. HI equals the product at completion.
- Back-to-back: new MULT 2×3 issued in the `md_done` cycle → second done after 33 more edges, `lo`=6, `hi`=0.
- ALU sweep:
  - SR `b`=0x80000000, `a`=4 → `sign`=1 gives 0xF8000000; `sign`=0 gives 0x08000000.
  - SLT −1 vs 1 → 1 signed, 0 unsigned.
  - LUI `b`=0xABCD → 0xABCD0000.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: MIPS execute-stage ALU with an iterative multiply/divide unit.
// The combinational ALU drives `result`. A shift-add multiplier and a restoring
// divider share one iteration datapath that writes the architectural HI/LO
// registers. Handshake: md_start / md_busy / md_done.
// Optional feature macro: ALU_MD_DIV_EN. Define it to compile the divider.
// When it is undefined, DIV requests run with MULT timing and leave HI/LO unchanged.

package alu_md_pkg;
  // ALU operation codes (EXE_ALU_*)
  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_XOR = 4'd4;
  localparam logic [3:0] EXE_ALU_NOR = 4'd5;
  localparam logic [3:0] EXE_ALU_SLT = 4'd6;
  localparam logic [3:0] EXE_ALU_LUI = 4'd7;
  localparam logic [3:0] EXE_ALU_SL  = 4'd8;
  localparam logic [3:0] EXE_ALU_SR  = 4'd9;

  // Multiply/divide unit operations
  localparam logic [1:0] MD_MULT = 2'd0;
  localparam logic [1:0] MD_DIV  = 2'd1;
  localparam logic [1:0] MD_MTHI = 2'd2;
  localparam logic [1:0] MD_MTLO = 2'd3;
endpackage

module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       oper,
  input  logic             sign,
  output logic [WIDTH-1:0] result,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // The counter must be able to hold WIDTH itself.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sra_res;
  logic             slt_s;
  logic             slt_u;

  assign shamt = a[SHW-1:0];
  // The arithmetic shift is kept in its own signal. Inside a mixed ternary the
  // signed operand would become unsigned, and the shift would then be logical.
  assign sra_res = $signed(b) >>> shamt;
  assign slt_s   = $signed(a) < $signed(b);
  assign slt_u   = a < b;

  // ALU result select; unknown opcodes return zero
  always_comb begin
    // NOTE: assign every always_comb output a default before the case.
    // Otherwise a path that skips the assignment infers a latch.
    result = '0;
    case (oper)
      EXE_ALU_ADD: result = a + b;
      EXE_ALU_SUB: result = a - b;
      EXE_ALU_AND: result = a & b;
      EXE_ALU_OR:  result = a | b;
      EXE_ALU_XOR: result = a ^ b;
      EXE_ALU_NOR: result = ~(a | b);
      EXE_ALU_SLT: result = WIDTH'(sign ? slt_s : slt_u);
      EXE_ALU_LUI: result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      EXE_ALU_SL:  result = b << shamt;
      EXE_ALU_SR:  result = sign ? sra_res : (b >> shamt);
      default:     result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide unit
  // acc : upper partial product (MULT) or partial remainder (DIV)
  // low : multiplier, becoming the lower product (MULT); dividend, becoming the quotient (DIV)
  // opnd: multiplicand (MULT) or divisor (DIV)
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;   // product/quotient must be negated
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_MD_DIV_EN
  logic             neg_r_q, neg_r_d;   // remainder takes the dividend's sign
  logic             dz_q, dz_d;         // divide by zero
`endif

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

  // One shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift {carry, acc, low} right by one.
  assign mul_sum  = low_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
  assign prod     = {acc_q, low_q};
  assign prod_fix = neg_p_q ? -prod : prod;

`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  // One restoring step: shift in the next dividend bit, then trial-subtract.
  // Bit WIDTH of the difference set means the subtraction borrowed.
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef ALU_MD_DIV_EN
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: begin
              is_div_d = (md_op == MD_DIV);
              neg_p_d  = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
              acc_d    = '0;
              low_d    = abs_b;
              opnd_d   = abs_a;
`ifdef ALU_MD_DIV_EN
              neg_r_d  = sign & a[WIDTH-1];
              dz_d     = (b == '0);
              if (md_op == MD_DIV) begin
                low_d  = abs_a;
                opnd_d = abs_b;
              end
`endif
              cnt_d    = CW'(WIDTH);
              state_d  = ST_RUN;
            end
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], 1'b0};
          end
        end
`endif
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`ifdef ALU_MD_DIV_EN
        else begin
          lo_d = dz_q ? '1 : (neg_p_q ? -low_q : low_q);
          hi_d = neg_r_q ? -acc_q : acc_q;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIX);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MD_DIV_EN
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, whatever the statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_MD_DIV_EN
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md (WIDTH=32).
// Stimulus pushes the expected HI/LO and the expected accept and done cycles.
// A negedge monitor checks busy/done on every cycle and pops the queue on each done.
// Expectations follow ALU_MD_DIV_EN in the same way as the design.
`timescale 1ns/1ps
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MSB  = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, result, hi, lo;
  logic [3:0]   oper;
  logic         sign, md_start, md_busy, md_done;
  logic [1:0]   md_op;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .oper(oper), .sign(sign),
    .result(result), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           done;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           running = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU, written from the operation definitions
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input bit s);
    int unsigned sh;
    sh = x[4:0];
    case (op)
      EXE_ALU_ADD: return x + y;
      EXE_ALU_SUB: return x - y;
      EXE_ALU_AND: return x & y;
      EXE_ALU_OR:  return x | y;
      EXE_ALU_XOR: return x ^ y;
      EXE_ALU_NOR: return ~(x | y);
      EXE_ALU_SLT: if (s) return ((x ^ MSB) < (y ^ MSB)) ? 1 : 0;
                   else   return (x < y) ? 1 : 0;
      EXE_ALU_LUI: return y << 16;
      EXE_ALU_SL:  return y << sh;
      EXE_ALU_SR:  if (s && y[31]) return (y >> sh) | ~(ONES >> sh);
                   else            return y >> sh;
      default:     return '0;
    endcase
  endfunction

  // Reference MULT/DIV in 64-bit integer arithmetic, returning {hi, lo}
  function automatic logic [2*W-1:0] ref_md(input bit is_div, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input bit s);
    logic [63:0] ux, uy, qv, rv;
    longint      sx, sy;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = s ? longint'($signed(x)) : longint'(ux);
    sy = s ? longint'($signed(y)) : longint'(uy);
    if (!is_div) begin
      if (s) return 64'(sx * sy);
      return ux * uy;
    end
    if (y == '0) return {x, ONES};
    qv = sx / sy;
    rv = sx % sy;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Issue MULT/DIV at a negedge while the unit is idle, then scramble the operands
  task automatic issue_md(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit s);
    logic [2*W-1:0] e;
    exp_t           it;
    a = x; b = y; sign = s; md_op = op; md_start = 1'b1;
    e = ref_md(op == MD_DIV, x, y, s);
`ifndef ALU_MD_DIV_EN
    if (op == MD_DIV) e = {m_hi, m_lo};
`endif
    m_hi = e[63:32];
    m_lo = e[31:0];
    it.hi = m_hi; it.lo = m_lo; it.acc = cyc + 1; it.done = cyc + W + 2;
    sb.push_back(it);
    @(negedge clk);
    md_start = 1'b0;
    a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
  endtask

  // MTHI/MTLO while idle; the register must hold the value one cycle later
  task automatic issue_mt(input bit to_hi, input logic [W-1:0] x);
    a = x; md_op = to_hi ? MD_MTHI : MD_MTLO; md_start = 1'b1;
    if (to_hi) m_hi = x; else m_lo = x;
    @(negedge clk);
    md_start = 1'b0;
    check(to_hi ? "mthi" : "mtlo", to_hi ? hi : lo, x);
    a = $urandom;
  endtask

  // Return at the negedge on which md_done is high (bounded)
  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_done) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_done: no md_done within 100 cycles (cycle %0d)", cyc);
  endtask

  task automatic alu_try(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit s);
    oper = op; a = x; b = y; sign = s;
    #1;
    check("alu_result", result, ref_alu(op, x, y, s));
  endtask

  // Monitor: busy/done every cycle; on done, HI/LO against the scoreboard head
  always @(negedge clk) begin : mon
    logic eb, ed;
    if (rst_n && running) begin
      eb = 1'b0;
      ed = 1'b0;
      if (sb.size() > 0) begin
        eb = (cyc >= sb[0].acc) && (cyc < sb[0].done);
        ed = (cyc == sb[0].done);
      end
      check("md_busy", md_busy, eb);
      check("md_done", md_done, ed);
      if (ed) begin
        check("hi", hi, sb[0].hi);
        check("lo", lo, sb[0].lo);
        void'(sb.pop_front());
      end else if (sb.size() > 0 && cyc > sb[0].done) begin
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    logic [1:0]   op;
    rst_n = 1'b0; a = '0; b = '0; oper = '0; sign = 1'b0; md_start = 1'b0; md_op = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", md_busy, 0);
    check("rst_done", md_done, 0);
    rst_n = 1'b1;
    running = 1'b1;
    @(negedge clk);

    // ALU: directed cases, then a random sweep
    alu_try(EXE_ALU_SR, 32'd4, 32'h8000_0000, 1'b1);
    check("sr_arith", result, 32'hF800_0000);
    alu_try(EXE_ALU_SR, 32'd4, 32'h8000_0000, 1'b0);
    check("sr_logic", result, 32'h0800_0000);
    alu_try(EXE_ALU_SLT, ONES, 32'd1, 1'b1);
    check("slt_signed", result, 1);
    alu_try(EXE_ALU_SLT, ONES, 32'd1, 1'b0);
    check("slt_unsigned", result, 0);
    alu_try(EXE_ALU_LUI, $urandom, 32'h0000_ABCD, 1'b0);
    check("lui", result, 32'hABCD_0000);
    for (int i = 0; i < 200; i++)
      alu_try(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    @(negedge clk);

    // Preload HI/LO, then reset during a MULT
    issue_mt(1'b1, 32'hDEAD_BEEF);
    issue_mt(1'b0, 32'h0BAD_F00D);
    issue_md(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", md_busy, 0);
    check("midrst_done", md_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_mt(1'b0, 32'h0000_1234);
    check("post_rst_hi", hi, 0);
    repeat (40) @(negedge clk);

    // Signed MULT -7 * 3
    issue_md(MD_MULT, -32'sd7, 32'd3, 1'b1);
    wait_done();
    check("smul_hi", hi, 32'hFFFF_FFFF);
    check("smul_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);

    // Divides
    issue_md(MD_DIV, 32'd100, 32'd7, 1'b0);   wait_done(); @(negedge clk);
    issue_md(MD_DIV, -32'sd7, 32'd2, 1'b1);   wait_done(); @(negedge clk);
    issue_md(MD_DIV, 32'd5, 32'd0, 1'b0);     wait_done(); @(negedge clk);
    issue_md(MD_DIV, -32'sd5, 32'd0, 1'b1);   wait_done(); @(negedge clk);
    issue_md(MD_DIV, MSB, ONES, 1'b1);        wait_done(); @(negedge clk);

    // MTHI and a second MULT request while busy are both ignored
    issue_md(MD_MULT, 32'h0001_0003, 32'h0002_0005, 1'b0);
    repeat (3) @(negedge clk);
    md_op = MD_MTHI; a = $urandom; md_start = 1'b1;
    @(negedge clk);
    md_op = MD_MULT; a = $urandom; b = $urandom;
    @(negedge clk);
    md_start = 1'b0;
    wait_done();

    // Back-to-back: issue in the done cycle
    issue_md(MD_MULT, 32'd2, 32'd3, 1'b0);
    wait_done();
    check("b2b_lo", lo, 6);
    check("b2b_hi", hi, 0);

    // Random MULT/DIV mix with random gaps and occasional MT ops
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 1));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = MSB; y = ONES; end
        2: y = 32'($urandom_range(1, 20));
        default: ;
      endcase
      issue_md(op, x, y, 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        if (md_done) @(negedge clk);
        issue_mt(1'($urandom_range(0, 1)), $urandom);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
